// File: rtl/sram_req_arbiter_pkg.sv
// Shared constants and types for the inst/data SRAM request arbiter.
package sram_req_arbiter_pkg;

  localparam int   ARB_MAX_OUTST_DEF = 4;
  localparam logic ARB_ID_INST       = 1'b0;
  localparam logic ARB_ID_DATA       = 1'b1;
  localparam int   SRAM_REQ_BUS_LEN  = 71;

  // Request payload in bus order: wr, size, wstrb, addr, wdata.
  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } sram_req_t;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_st_e;

endpackage

// File: rtl/sram_req_arbiter_if.sv
// SRAM-like request channel (req/addr_ok/data_ok); master issues requests.
interface sram_req_arbiter_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (output req, wr, size, wstrb, addr, wdata,
                  input  addr_ok, data_ok, rdata);
  modport slave  (input  req, wr, size, wstrb, addr, wdata,
                  output addr_ok, data_ok, rdata);
endinterface

// File: rtl/arb_order_fifo.sv
// Issue-order FIFO of requester IDs; depth MAX_OUTST (power of two), registered count.
module arb_order_fifo #(
  parameter int MAX_OUTST = 4,
  parameter int ID_W      = 1
)(
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       push,
  input  logic                       pop,
  input  logic [ID_W-1:0]            din,
  output logic [ID_W-1:0]            dout,
  output logic [$clog2(MAX_OUTST):0] count
);
  localparam int PW = $clog2(MAX_OUTST);

  logic [MAX_OUTST-1:0][ID_W-1:0] ent_q;
  logic [PW-1:0]                  wr_ptr, rd_ptr;

  // Caller guarantees no push when full and no pop when empty.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) ent_q[wr_ptr] <= din;
  end

  assign dout = ent_q[rd_ptr];

endmodule

// File: rtl/sram_req_arbiter.sv
// Shares one SRAM-like channel between fetch and data requesters, routing responses in issue order.
// Build option SRAM_ARB_RR_EN: round-robin between simultaneous requests instead of data priority.
module sram_req_arbiter
  import sram_req_arbiter_pkg::*;
#(
  parameter int MAX_OUTST = ARB_MAX_OUTST_DEF,
  parameter int ID_W      = 1
)(
  input  logic                        clk,
  input  logic                        resetn,
  sram_req_arbiter_if.slave           inst,
  sram_req_arbiter_if.slave           data,
  sram_req_arbiter_if.master          mem,
  output logic [$clog2(MAX_OUTST):0]  outst_cnt
);
  localparam logic [ID_W-1:0] ID_INST = ID_W'(ARB_ID_INST);
  localparam logic [ID_W-1:0] ID_DATA = ID_W'(ARB_ID_DATA);

  arb_st_e         state_q, state_d;
  logic [ID_W-1:0] owner_q, owner_d, grant, pick, head;
  logic            owner_req, gnt_req, full, xfer, pop;
  sram_req_t       inst_r, data_r, gnt_r;

  assign inst_r = {inst.wr, inst.size, inst.wstrb, inst.addr, inst.wdata};
  assign data_r = {data.wr, data.size, data.wstrb, data.addr, data.wdata};

  // Full uses the registered count so a same-cycle pop never unblocks a push.
  assign full      = (outst_cnt == ($clog2(MAX_OUTST)+1)'(MAX_OUTST));
  assign owner_req = (owner_q == ID_DATA) ? data.req : inst.req;

`ifdef SRAM_ARB_RR_EN
  logic [ID_W-1:0] rr_q;

  assign pick = (data.req && inst.req) ? ((rr_q == ID_DATA) ? ID_INST : ID_DATA)
                                       : (data.req ? ID_DATA : ID_INST);

  always_ff @(posedge clk) begin
    if (!resetn)   rr_q <= ID_INST;
    else if (xfer) rr_q <= grant;
  end
`else
  assign pick = data.req ? ID_DATA : ID_INST;
`endif

  // A withdrawn locked request falls through to normal selection this cycle.
  assign grant   = (state_q == ARB_LOCKED && owner_req) ? owner_q : pick;
  assign gnt_req = (grant == ID_DATA) ? data.req : inst.req;
  assign gnt_r   = (grant == ID_DATA) ? data_r : inst_r;

  assign mem.req   = gnt_req & ~full;
  assign mem.wr    = gnt_r.wr;
  assign mem.size  = gnt_r.size;
  assign mem.wstrb = gnt_r.wstrb;
  assign mem.addr  = gnt_r.addr;
  assign mem.wdata = gnt_r.wdata;

  assign xfer         = mem.req & mem.addr_ok;
  assign inst.addr_ok = xfer & (grant == ID_INST);
  assign data.addr_ok = xfer & (grant == ID_DATA);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= ARB_IDLE;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  always_comb begin
    state_d = ARB_IDLE;
    owner_d = owner_q;
    if (mem.req && !mem.addr_ok) begin
      state_d = ARB_LOCKED;
      owner_d = grant;
    end
  end

  assign pop = mem.data_ok & (outst_cnt != '0);

  arb_order_fifo #(.MAX_OUTST(MAX_OUTST), .ID_W(ID_W)) u_order (
    .clk    (clk),
    .resetn (resetn),
    .push   (xfer),
    .pop    (pop),
    .din    (grant),
    .dout   (head),
    .count  (outst_cnt)
  );

  assign inst.data_ok = pop & (head == ID_INST);
  assign data.data_ok = pop & (head == ID_DATA);
  assign inst.rdata   = mem.rdata;
  assign data.rdata   = mem.rdata;

  always_ff @(posedge clk) begin
    if (resetn) begin
      assert (!(mem.data_ok && outst_cnt == '0))
        else $warning("mem_data_ok with no request outstanding");
    end
  end

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Randomized bench for sram_req_arbiter with an issue-order queue model plus directed literal checks.
module tb_sram_req_arbiter;
  import sram_req_arbiter_pkg::*;

  localparam int MAXO = 4;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic [$clog2(MAXO):0] outst_cnt;

  sram_req_arbiter_if inst_if();
  sram_req_arbiter_if data_if();
  sram_req_arbiter_if mem_if();

  sram_req_arbiter #(.MAX_OUTST(MAXO), .ID_W(1)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .inst      (inst_if),
    .data      (data_if),
    .mem       (mem_if),
    .outst_cnt (outst_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  // Model: issued IDs in order (0=inst, 1=data), pending stalled owner, last winner.
  int mq[$];
  bit lk_v = 1'b0;
  int lk_o = 0;
  int last_win = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    int g;
    bit greq, em, ex, ep;
    int hd;
    if (chk_en) begin
      if (lk_v && ((lk_o == 1) ? data_if.req : inst_if.req)) g = lk_o;
      else if (data_if.req && inst_if.req) begin
`ifdef SRAM_ARB_RR_EN
        g = (last_win == 1) ? 0 : 1;
`else
        g = 1;
`endif
      end else g = data_if.req ? 1 : 0;
      greq = (g == 1) ? data_if.req : inst_if.req;
      em = greq && (mq.size() < MAXO);
      ex = em && mem_if.addr_ok;
      ep = mem_if.data_ok && (mq.size() > 0);
      hd = ep ? mq[0] : -1;

      check("mem_req", {31'd0, mem_if.req}, {31'd0, em});
      check("inst_addr_ok", {31'd0, inst_if.addr_ok}, {31'd0, ex && g == 0});
      check("data_addr_ok", {31'd0, data_if.addr_ok}, {31'd0, ex && g == 1});
      check("inst_data_ok", {31'd0, inst_if.data_ok}, {31'd0, ep && hd == 0});
      check("data_data_ok", {31'd0, data_if.data_ok}, {31'd0, ep && hd == 1});
      check("outst_cnt", 32'(outst_cnt), 32'(mq.size()));
      if (em) begin
        check("mem_addr", mem_if.addr, (g == 1) ? data_if.addr : inst_if.addr);
        check("mem_wdata", mem_if.wdata, (g == 1) ? data_if.wdata : inst_if.wdata);
        check("mem_ctl", {25'd0, mem_if.wr, mem_if.size, mem_if.wstrb},
              (g == 1) ? {25'd0, data_if.wr, data_if.size, data_if.wstrb}
                       : {25'd0, inst_if.wr, inst_if.size, inst_if.wstrb});
      end
      if (ep) begin
        check("inst_rdata", inst_if.rdata, mem_if.rdata);
        check("data_rdata", data_if.rdata, mem_if.rdata);
      end

      if (!resetn) begin
        mq.delete();
        lk_v = 1'b0;
        lk_o = 0;
        last_win = 0;
      end else begin
        if (ep) void'(mq.pop_front());
        if (ex) begin
          mq.push_back(g);
          last_win = g;
        end
        lk_v = em && !mem_if.addr_ok;
        if (lk_v) lk_o = g;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    inst_if.req = 1'b0;
    data_if.req = 1'b0;
    mem_if.addr_ok = 1'b0;
    mem_if.data_ok = 1'b0;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) begin
      mem_if.data_ok = 1'b1;
      tick();
    end
    mem_if.data_ok = 1'b0;
  endtask

  initial begin
    int ids[3];
    logic [31:0] rv[3];
    ids = '{0, 1, 0};
    rv  = '{32'hA, 32'hB, 32'hC};

    idle();
    inst_if.wr = 1'b0; inst_if.size = 2'd2; inst_if.wstrb = 4'hf;
    inst_if.addr = 32'h1c000000; inst_if.wdata = 32'h0;
    data_if.wr = 1'b0; data_if.size = 2'd2; data_if.wstrb = 4'hf;
    data_if.addr = 32'h00001000; data_if.wdata = 32'h0;
    mem_if.rdata = 32'h0;
    resetn = 1'b0;
    tick();
    chk_en = 1'b1;
    tick(); tick();
    resetn = 1'b1;
    at_neg();
    check("rst_outst_cnt", 32'(outst_cnt), 32'd0);
    check("rst_mem_req", {31'd0, mem_if.req}, 32'd0);
    check("rst_addr_ok", {30'd0, inst_if.addr_ok, data_if.addr_ok}, 32'd0);
    tick();

    // Both requesting: data first, then inst.
    inst_if.req = 1'b1; data_if.req = 1'b1; mem_if.addr_ok = 1'b1;
    at_neg();
    check("t1_c0_addr", mem_if.addr, 32'h00001000);
    check("t1_c0_data_aok", {31'd0, data_if.addr_ok}, 32'd1);
    check("t1_c0_inst_aok", {31'd0, inst_if.addr_ok}, 32'd0);
    tick();
    data_if.req = 1'b0;
    at_neg();
    check("t1_c1_addr", mem_if.addr, 32'h1c000000);
    check("t1_c1_inst_aok", {31'd0, inst_if.addr_ok}, 32'd1);
    tick();
    idle();
    mem_if.data_ok = 1'b1; mem_if.rdata = 32'h11;
    at_neg();
    check("t1_r0_data_dok", {31'd0, data_if.data_ok}, 32'd1);
    check("t1_r0_inst_dok", {31'd0, inst_if.data_ok}, 32'd0);
    check("t1_r0_rdata", data_if.rdata, 32'h11);
    tick();
    mem_if.rdata = 32'h22;
    at_neg();
    check("t1_r1_inst_dok", {31'd0, inst_if.data_ok}, 32'd1);
    check("t1_r1_data_dok", {31'd0, data_if.data_ok}, 32'd0);
    check("t1_r1_rdata", inst_if.rdata, 32'h22);
    tick();
    idle();

    // Stalled data request holds the grant.
    data_if.req = 1'b1; inst_if.req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      at_neg();
      check("t2_hold_addr", mem_if.addr, 32'h00001000);
      check("t2_hold_inst_aok", {31'd0, inst_if.addr_ok}, 32'd0);
      check("t2_hold_mem_req", {31'd0, mem_if.req}, 32'd1);
      tick();
    end
    mem_if.addr_ok = 1'b1;
    at_neg();
    check("t2_data_aok", {31'd0, data_if.addr_ok}, 32'd1);
    check("t2_inst_aok", {31'd0, inst_if.addr_ok}, 32'd0);
    tick();
    idle();
    drain(1);

    // In-order return routing.
    for (int i = 0; i < 3; i++) begin
      inst_if.req = (ids[i] == 0); data_if.req = (ids[i] == 1); mem_if.addr_ok = 1'b1;
      at_neg();
      check("t3_issue_aok", {31'd0, (ids[i] == 0) ? inst_if.addr_ok : data_if.addr_ok}, 32'd1);
      tick();
    end
    idle();
    for (int i = 0; i < 3; i++) begin
      mem_if.data_ok = 1'b1; mem_if.rdata = rv[i];
      at_neg();
      check("t3_inst_dok", {31'd0, inst_if.data_ok}, {31'd0, ids[i] == 0});
      check("t3_data_dok", {31'd0, data_if.data_ok}, {31'd0, ids[i] == 1});
      check("t3_rdata", (ids[i] == 0) ? inst_if.rdata : data_if.rdata, rv[i]);
      tick();
    end
    idle();

    // Full: a same-cycle pop does not admit a push.
    inst_if.req = 1'b1; mem_if.addr_ok = 1'b1;
    for (int i = 0; i < MAXO; i++) tick();
    at_neg();
    check("t4_full_cnt", 32'(outst_cnt), 32'd4);
    check("t4_full_mem_req", {31'd0, mem_if.req}, 32'd0);
    tick();
    mem_if.data_ok = 1'b1;
    at_neg();
    check("t4_pop_mem_req", {31'd0, mem_if.req}, 32'd0);
    check("t4_pop_inst_aok", {31'd0, inst_if.addr_ok}, 32'd0);
    check("t4_pop_inst_dok", {31'd0, inst_if.data_ok}, 32'd1);
    tick();
    mem_if.data_ok = 1'b0;
    at_neg();
    check("t4_after_cnt", 32'(outst_cnt), 32'd3);
    check("t4_after_inst_aok", {31'd0, inst_if.addr_ok}, 32'd1);
    tick();
    inst_if.req = 1'b0;
    at_neg();
    check("t4_refill_cnt", 32'(outst_cnt), 32'd4);
    tick();
    idle();
    drain(MAXO);
    at_neg();
    check("t4_drained_cnt", 32'(outst_cnt), 32'd0);
    tick();

    // Locked data request withdrawn: inst takes the channel the same cycle.
    data_if.req = 1'b1; inst_if.req = 1'b1; mem_if.addr_ok = 1'b0;
    at_neg();
    check("t5_lock_addr", mem_if.addr, 32'h00001000);
    tick();
    data_if.req = 1'b0; mem_if.addr_ok = 1'b1;
    at_neg();
    check("t5_drop_addr", mem_if.addr, 32'h1c000000);
    check("t5_drop_inst_aok", {31'd0, inst_if.addr_ok}, 32'd1);
    check("t5_drop_data_aok", {31'd0, data_if.addr_ok}, 32'd0);
    tick();
    inst_if.req = 1'b0; data_if.req = 1'b1;
    at_neg();
    check("t5_next_data_aok", {31'd0, data_if.addr_ok}, 32'd1);
    tick();
    idle();
    drain(2);

    // Reset with requests outstanding, then a spurious response.
    inst_if.req = 1'b1; mem_if.addr_ok = 1'b1;
    tick(); tick();
    idle();
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    at_neg();
    check("t6_cnt_after_rst", 32'(outst_cnt), 32'd0);
    tick();
    mem_if.data_ok = 1'b1;
    at_neg();
    check("t6_spurious_dok", {30'd0, inst_if.data_ok, data_if.data_ok}, 32'd0);
    tick();
    idle();

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      inst_if.req   = ($urandom_range(0, 3) != 0);
      data_if.req   = ($urandom_range(0, 1) != 0);
      inst_if.wr    = $urandom_range(0, 1) != 0;
      inst_if.size  = 2'($urandom_range(0, 2));
      inst_if.wstrb = 4'($urandom);
      inst_if.addr  = $urandom;
      inst_if.wdata = $urandom;
      data_if.wr    = $urandom_range(0, 1) != 0;
      data_if.size  = 2'($urandom_range(0, 2));
      data_if.wstrb = 4'($urandom);
      data_if.addr  = $urandom;
      data_if.wdata = $urandom;
      mem_if.addr_ok = ($urandom_range(0, 9) < 6);
      mem_if.data_ok = (mq.size() > 0) && ($urandom_range(0, 1) != 0);
      mem_if.rdata   = $urandom;
      resetn = ($urandom_range(0, 499) != 0);
      tick();
    end

    idle();
    resetn = 1'b1;
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_req_arbiter.md
Name: sram_req_arbiter

Overview:
- Shares one SRAM-like memory request channel (req/addr_ok/data_ok) between the instruction-fetch requester and the EXE-stage data requester.
- Sits between the pipeline's inst_sram/data_sram interfaces and the cache/AXI bridge side.
- Selects one requester per cycle and holds the grant until the address handshake completes.
- Tracks outstanding requests in issue order so that each data_ok/rdata return is routed back to the requester that issued it.

Parameters:
- MAX_OUTST, 4, maximum in-flight (addr accepted, data_ok pending) requests; power of two, at least 2.
- ID_W, 1, width of the requester ID stored per outstanding entry.

Ports:
- clk  in  1  clock
- resetn  in  1  reset
- inst_req  in  1  fetch request valid
- inst_wr  in  1  fetch write flag (always 0 in practice; still forwarded)
- inst_size  in  2  0=byte, 1=half, 2=word
- inst_wstrb  in  4  byte enables
- inst_addr  in  32  physical address
- inst_wdata  in  32  write data
- inst_addr_ok  out  1  fetch request accepted
- inst_data_ok  out  1  fetch response valid
- inst_rdata  out  32  fetch read data
- data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata  in  1/1/2/4/32/32  same meaning for the data requester
- data_addr_ok  out  1  data request accepted
- data_data_ok  out  1  data response valid
- data_rdata  out  32  data read data
- mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata  out  1/1/2/4/32/32  shared channel request
- mem_addr_ok  in  1  shared channel accepted
- mem_data_ok  in  1  shared channel response
- mem_rdata  in  32  response data
- outst_cnt  out  $clog2(MAX_OUTST)+1  in-flight count (debug/perf)

Behaviour:
- Reset: resetn is synchronous, active-low; clk is the clock.
  - On reset: lock=0, lock_owner=0, order FIFO empty, outst_cnt=0, rr pointer=0.
  - All *_addr_ok, *_data_ok and mem_req are 0 during and after reset until a request arrives.
  - Reset mid-operation discards in-flight tracking; the memory side is reset in the same cycle.
- Grant selection (combinational, computed each cycle):
  - If lock=1, grant=lock_owner.
  - Else if data_req, grant=DATA; else if inst_req, grant=INST.
- mem_req = req of the granted requester AND outst_cnt < MAX_OUTST.
  - mem_wr, mem_size, mem_wstrb, mem_addr and mem_wdata are muxed from the granted requester.
- Address handshake: a transfer occurs when mem_req & mem_addr_ok.
  - The granted requester's *_addr_ok equals that transfer signal. The other requester's *_addr_ok is 0.
  - Each transfer pushes the grant ID into the order FIFO.
- Lock register:
  - Set when mem_req=1 and mem_addr_ok=0; lock_owner=grant.
  - Cleared on transfer.
  - Also cleared if the locked owner's req drops. The data stage may withdraw a request on exception; in that cycle grant falls through to normal selection, so the other requester can issue that same cycle.
- Full: when outst_cnt==MAX_OUTST, mem_req=0 and no transfer occurs.
  - Full is evaluated on the registered count, so a same-cycle pop does not unblock a push.
  - The lock is not set while full.
- Response: mem_data_ok pops the FIFO head.
  - head==INST raises inst_data_ok; head==DATA raises data_data_ok.
  - inst_rdata and data_rdata are both driven by mem_rdata.
  - Responses are strictly in issue order; there is no combinational path from mem_data_ok to mem_req.
- Simultaneous push and pop: outst_cnt is unchanged and both pointers advance.
- mem_data_ok with an empty FIFO: ignored, no *_data_ok raised. A simulation assertion fires.
- Pointer wrap: pointers are $clog2(MAX_OUTST) bits and wrap modulo MAX_OUTST; the count disambiguates full from empty.
- No cancel path: every accepted request receives its data_ok; pipeline stages discard stale responses themselves.

Optional Feature:
- Macro: SRAM_ARB_RR_EN.
- Defined: when both reqs are high and lock=0, grant goes to the requester opposite the rr pointer's last winner. The rr pointer updates to the winner on each transfer.
- Undefined: fixed data-over-inst priority; no rr register is synthesized.

Decomposition:
- Constants go in the shared header alongside the existing bus-width defines:
  - ARB_ID_INST=1'b0, ARB_ID_DATA=1'b1
  - SRAM_REQ_BUS_LEN=71 (wr+size+wstrb+addr+wdata)
  - default MAX_OUTST
- Sub-module arb_order_fifo: synchronous FIFO of ID_W-bit entries.
  - Ports: push, pop, din, dout, count.
  - Depth is the MAX_OUTST parameter, with registered count.

Test Plan:
- Both reqs high at 0x1c000000 (inst) and 0x00001000 (data), mem_addr_ok=1 → data granted in cycle 0 and inst in cycle 1. With SRAM_ARB_RR_EN and last winner=DATA, inst is granted first.
- data_req held for 3 cycles while mem_addr_ok=0, inst_req also high → mem_addr stays 0x00001000 throughout and inst_addr_ok stays 0 until data transfers.
- Issue INST, DATA, INST, then return 3 data_ok with rdata 0xA, 0xB, 0xC → inst_data_ok carries 0xA, data_data_ok carries 0xB, inst_data_ok carries 0xC.
- Issue 4 requests without data_ok (MAX_OUTST=4) → outst_cnt=4 and mem_req=0 with a pending req. Assert data_ok and a new req in the same cycle → no push that cycle; the push occurs next cycle and outst_cnt returns to 4.
- Locked data request: data_req drops while mem_addr_ok=0 and inst_req is high → inst is granted the same cycle and the lock is cleared.
- Reset pulse with 2 requests outstanding → outst_cnt=0. A subsequent spurious mem_data_ok raises no *_data_ok.
